// File: rtl/matmul_pkg.sv
// Shared types and constants for the 2x2 systolic matmul sequencer.
package matmul_pkg;

    localparam int unsigned N           = 2;
    localparam int unsigned FEED_CYCLES = 2 * N - 1;
    localparam int unsigned NELEM       = N * N;
    localparam int unsigned STEP_W      = 2;

    // Row-major element positions within a latched 2x2 operand.
    localparam logic [1:0] IDX_00 = 2'd0;
    localparam logic [1:0] IDX_01 = 2'd1;
    localparam logic [1:0] IDX_10 = 2'd2;
    localparam logic [1:0] IDX_11 = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FEED,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/matmul_seq_skew.sv
// Maps latched operands and a feed step to the skewed row/column streams:
// a_row_i = A[i][t-i], b_col_j = B[t-j][j], zero when the index falls outside 0..1.
module matmul_seq_skew
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] la [NELEM],
    input  logic [DATA_W-1:0] lb [NELEM],
    input  logic [STEP_W-1:0] step,
    output logic [DATA_W-1:0] a_row0,
    output logic [DATA_W-1:0] a_row1,
    output logic [DATA_W-1:0] b_col0,
    output logic [DATA_W-1:0] b_col1
);

    // Select the diagonal wavefront of A and B for this step.
    always_comb begin
        a_row0 = '0;
        a_row1 = '0;
        b_col0 = '0;
        b_col1 = '0;
        case (step)
            2'd0: begin
                a_row0 = la[IDX_00];
                b_col0 = lb[IDX_00];
            end
            2'd1: begin
                a_row0 = la[IDX_01];
                a_row1 = la[IDX_10];
                b_col0 = lb[IDX_10];
                b_col1 = lb[IDX_01];
            end
            2'd2: begin
                a_row1 = la[IDX_11];
                b_col1 = lb[IDX_11];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/matmul_seq.sv
// Sequencer for one 2x2 multiply on an output-stationary systolic array:
// latches operands, clears PEs, feeds skewed streams, drains, pulses done.
// Optional MATMUL_SEQ_PERF_CNT_EN adds a saturating 16-bit op_count output.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a2,
    input  logic [DATA_W-1:0] a3,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] b2,
    input  logic [DATA_W-1:0] b3,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] a_row0,
    output logic [DATA_W-1:0] a_row1,
    output logic [DATA_W-1:0] b_col0,
    output logic [DATA_W-1:0] b_col1,
    output logic              pe_clear,
    output logic              feed_valid
`ifdef MATMUL_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]       op_count
`endif
);

    localparam int unsigned       DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(FEED_CYCLES - 1);
    localparam logic [DCW-1:0]    LAST_DRAIN = DCW'(DRAIN_CYCLES - 1);

    state_t              state, state_nx;
    logic [STEP_W-1:0]   step, step_nx;
    logic [DCW-1:0]      dcnt, dcnt_nx;
    logic [DATA_W-1:0]   la [NELEM];
    logic [DATA_W-1:0]   lb [NELEM];
    logic [DATA_W-1:0]   sk_a0, sk_a1, sk_b0, sk_b1;

    // Next-state, step and drain counter decisions.
    always_comb begin
        state_nx = state;
        step_nx  = step;
        dcnt_nx  = dcnt;
        case (state)
            IDLE: if (start) state_nx = LOAD;
            LOAD: begin
                state_nx = FEED;
                step_nx  = '0;
            end
            FEED: begin
                if (step == LAST_STEP) begin
                    dcnt_nx  = '0;
                    state_nx = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                end else begin
                    step_nx = step + 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt == LAST_DRAIN) state_nx = DONE;
                else                    dcnt_nx  = dcnt + 1'b1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stream values come from the step about to be entered so they appear registered.
    matmul_seq_skew #(
        .DATA_W (DATA_W)
    ) u_skew (
        .la     (la),
        .lb     (lb),
        .step   (step_nx),
        .a_row0 (sk_a0),
        .a_row1 (sk_a1),
        .b_col0 (sk_b0),
        .b_col1 (sk_b1)
    );

    // State, counters and operand latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            step  <= '0;
            dcnt  <= '0;
            for (int unsigned i = 0; i < NELEM; i++) begin
                la[i] <= '0;
                lb[i] <= '0;
            end
        end else begin
            state <= state_nx;
            step  <= step_nx;
            dcnt  <= dcnt_nx;
            if (state == IDLE && start) begin
                la[0] <= a0;
                la[1] <= a1;
                la[2] <= a2;
                la[3] <= a3;
                lb[0] <= b0;
                lb[1] <= b1;
                lb[2] <= b2;
                lb[3] <= b3;
            end
        end
    end

    // Outputs decoded from the next state so each is a flop aligned with its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            pe_clear   <= 1'b0;
            feed_valid <= 1'b0;
            a_row0     <= '0;
            a_row1     <= '0;
            b_col0     <= '0;
            b_col1     <= '0;
        end else begin
            busy       <= (state_nx != IDLE);
            done       <= (state_nx == DONE);
            pe_clear   <= (state_nx == LOAD);
            feed_valid <= (state_nx == FEED);
            if (state_nx == FEED) begin
                a_row0 <= sk_a0;
                a_row1 <= sk_a1;
                b_col0 <= sk_b0;
                b_col1 <= sk_b1;
            end else begin
                a_row0 <= '0;
                a_row1 <= '0;
                b_col0 <= '0;
                b_col1 <= '0;
            end
        end
    end

`ifdef MATMUL_SEQ_PERF_CNT_EN
    // Completed-operation counter, saturating at all ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                    op_count <= '0;
        else if (state == DONE && op_count != '1)      op_count <= op_count + 16'd1;
    end
`endif

endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand element width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 2, cycles after last feed before done (PE pipeline flush).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have ports a0..a3  input  DATA_W each  matrix A, row-major: A00, A01, A10, A11.
REQ-006 SHALL have ports b0..b3  input  DATA_W each  matrix B, row-major: B00, B01, B10, B11.
REQ-007 SHALL have port start  input  1  request one 2x2 multiply.
REQ-008 SHALL have ports busy, done  output  1 each  in operation, single-cycle completion pulse.
REQ-009 SHALL have ports a_row0, a_row1, b_col0, b_col1  output  DATA_W each  skewed operand streams to a 2x2 output-stationary systolic array.
REQ-010 SHALL have ports pe_clear, feed_valid  output  1 each  PE accumulator clear, operand streams valid.

Function
REQ-011 SHALL implement states IDLE, LOAD, FEED, DRAIN, DONE.
REQ-012 SHALL accept start only in IDLE; on acceptance latch a0..a3, b0..b3 and enter LOAD; start in any other state ignored.
REQ-013 LOAD: one cycle, pe_clear=1, then FEED.
REQ-014 FEED: 3 cycles (t=0,1,2), feed_valid=1, then DRAIN.
REQ-015 At FEED step t: a_row_i = A[i][t-i], b_col_j = B[t-j][j] when index in 0..1, else 0.
REQ-016 DRAIN: DRAIN_CYCLES cycles, streams 0, feed_valid=0, then DONE; DRAIN_CYCLES=0 goes FEED->DONE directly.
REQ-017 DONE: one cycle, done=1, then IDLE; start in DONE ignored (earliest re-accept is the following IDLE cycle).
REQ-018 busy=1 in LOAD, FEED, DRAIN, DONE; 0 in IDLE.
REQ-019 Operand inputs changing after acceptance SHALL NOT affect the running operation.
REQ-020 All outputs registered; stream values of step t present during that FEED cycle.
REQ-021 Latency DRAIN_CYCLES=2: start sampled at edge 0 -> LOAD cycle 1, FEED cycles 2-4, DRAIN 5-6, done cycle 7.

Reset
REQ-022 Reset low SHALL immediately force IDLE, busy=0, done=0, pe_clear=0, feed_valid=0, all streams 0, latched operands 0, regardless of state.
REQ-023 Reset mid-operation SHALL abandon the operation with no done pulse; first start after deassertion begins a fresh operation.

Configuration
REQ-024 Macro MATMUL_SEQ_PERF_CNT_EN defined: extra output op_count (16 bits), 0 at reset, +1 each DONE cycle, saturates at 16'hFFFF.
REQ-025 Macro undefined: op_count port and counter absent; all other behaviour identical.

Structure
REQ-026 Package matmul_pkg SHALL hold: state enum, N=2, FEED_CYCLES=2*N-1, element index constants.
REQ-027 Sub-module matmul_seq_skew (combinational: latched operands + step index -> four stream values) SHALL be instantiated once; FSM, step counter and drain counter remain in matmul_seq.

Verification
REQ-028 A=[1 2;3 4], B=[3 4;5 6], start 1 cycle -> FEED streams (a_row0,a_row1,b_col0,b_col1): t0 (1,0,3,0), t1 (2,3,5,4), t2 (0,4,0,6); done at cycle 7.
REQ-029 Same operands into bench 2x2 PE model -> C = [13 16; 29 36] when done=1.
REQ-030 start held high continuously -> ops start every 8 cycles, done single-cycle each, no start accepted while busy.
REQ-031 Change a0..b3 to 8'd9 during FEED -> streams still from latched values of REQ-028.
REQ-032 Reset low during FEED t1 -> all outputs 0 immediately, no done; next start gives REQ-028 sequence.
REQ-033 With MATMUL_SEQ_PERF_CNT_EN, 3 operations -> op_count=3; forced count 16'hFFFF + 1 op -> stays 16'hFFFF.
